// File: rtl/float_norm_round_pkg.sv
// Shared float format definitions for the float_div_nb datapath.
// Single-precision defaults, packed result layout and canonical special encodings.
package float_norm_round_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 2**(FP_EXP_W-1) - 1;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] frac;
  } float_t;

  localparam float_t FLOAT_QNAN = '{sign: 1'b0, exp: '1, frac: {1'b1, {(FP_MAN_W-1){1'b0}}}};
  localparam float_t FLOAT_INF  = '{sign: 1'b0, exp: '1, frac: '0};

endpackage

// File: rtl/float_norm_round_lead_nz.sv
// Leading-zero counter: returns the number of zero bits above the most
// significant set bit of din, or WIDTH when din is zero.
module lead_nz #(
  parameter  int WIDTH = 27,
  localparam int CW    = $clog2(WIDTH+1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    count
);

  logic found;

  always_comb begin
    count = CW'(WIDTH);
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && din[WIDTH-1-i]) begin
        count = CW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/float_norm_round.sv
// Two-stage normalise / round-to-nearest-even / pack stage after the mantissa divider.
// Optional flag outputs (out_ovf, out_unf, out_inexact) enabled by FLOAT_NORM_FLAGS_EN.
module float_norm_round
  import float_norm_round_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int QW    = MAN_W + 4,
  parameter int BIAS  = 2**(EXP_W-1) - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic signed [EXP_W+1:0]  in_exp,
  input  logic [QW-1:0]            in_man,
  input  logic                     in_sticky,
  input  logic                     in_inf,
  input  logic                     in_nan,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     dout
`ifdef FLOAT_NORM_FLAGS_EN
  ,
  output logic                     out_ovf,
  output logic                     out_unf,
  output logic                     out_inexact
`endif
);

  localparam int LZ_W  = $clog2(QW+1);
  localparam int EW    = EXP_W + 2;
  localparam int XW    = EXP_W + 3;
  localparam int LOW_W = QW - 2 - MAN_W;

  if (BIAS < 1) begin : g_bad_bias
    $error("float_norm_round: BIAS must be positive");
  end

  logic s1_valid, s2_valid, s1_adv, s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Stage 1: normalise
  logic [LZ_W-1:0] lz;
  logic [XW-1:0]   exp_wide;
  logic [EW-1:0]   exp_n;

  lead_nz #(.WIDTH(QW)) u_lead_nz (
    .din   (in_man),
    .count (lz)
  );

  // Widened subtract; a result below the signed EW range clamps to its minimum,
  // which still lands in the flush-to-zero case.
  assign exp_wide = {in_exp[EW-1], in_exp} - {{(XW-LZ_W){1'b0}}, lz};
  assign exp_n    = (exp_wide[XW-1] != exp_wide[XW-2]) ? {1'b1, {(EW-1){1'b0}}}
                                                       : exp_wide[EW-1:0];

  logic          s1_sign, s1_sticky, s1_inf, s1_nan;
  logic [EW-1:0] s1_exp;
  logic [QW-1:0] s1_man;

  // Stage 2: round and pack
  logic [MAN_W:0]        sig;
  logic                  guard, sticky_all, round_up, ovf, unf, is_zero;
  logic [MAN_W+1:0]      sum;
  logic [XW-1:0]         exp_r;
  logic [EXP_W+MAN_W:0]  d_next;
`ifdef FLOAT_NORM_FLAGS_EN
  logic f_ovf, f_unf, f_inexact;
`endif

  assign sig        = s1_man[QW-1 -: MAN_W+1];
  assign guard      = s1_man[LOW_W];
  assign sticky_all = (|s1_man[LOW_W-1:0]) | s1_sticky;
  assign round_up   = guard & (sticky_all | sig[0]);
  assign sum        = {1'b0, sig} + (MAN_W+2)'(round_up);
  assign exp_r      = {s1_exp[EW-1], s1_exp} + XW'(sum[MAN_W+1]);
  assign ovf        = !exp_r[XW-1] && (exp_r[XW-2:0] >= (XW-1)'(2**EXP_W - 1));
  assign unf        = exp_r[XW-1] || (exp_r == '0);
  assign is_zero    = (s1_man == '0);

  always_comb begin
    d_next = {s1_sign, exp_r[EXP_W-1:0], sum[MAN_W-1:0]};
`ifdef FLOAT_NORM_FLAGS_EN
    f_ovf     = 1'b0;
    f_unf     = 1'b0;
    f_inexact = 1'b0;
`endif
    if (s1_nan) begin
      d_next = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (s1_inf) begin
      d_next = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (is_zero) begin
      d_next = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (ovf) begin
      d_next = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FLOAT_NORM_FLAGS_EN
      f_ovf     = 1'b1;
      f_inexact = 1'b1;
`endif
    end else if (unf) begin
      d_next = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
`ifdef FLOAT_NORM_FLAGS_EN
      f_unf     = 1'b1;
      f_inexact = 1'b1;
`endif
    end else begin
`ifdef FLOAT_NORM_FLAGS_EN
      f_inexact = guard | sticky_all;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_man    <= '0;
      s1_sticky <= 1'b0;
      s1_inf    <= 1'b0;
      s1_nan    <= 1'b0;
      s2_valid  <= 1'b0;
      dout      <= '0;
`ifdef FLOAT_NORM_FLAGS_EN
      out_ovf     <= 1'b0;
      out_unf     <= 1'b0;
      out_inexact <= 1'b0;
`endif
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign   <= in_sign;
          s1_exp    <= exp_n;
          s1_man    <= in_man << lz;
          s1_sticky <= in_sticky;
          s1_inf    <= in_inf;
          s1_nan    <= in_nan;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          dout <= d_next;
`ifdef FLOAT_NORM_FLAGS_EN
          out_ovf     <= f_ovf;
          out_unf     <= f_unf;
          out_inexact <= f_inexact;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_float_norm_round.sv
// Scoreboard bench for float_norm_round: directed numeric cases, stall/hold and
// mid-stall reset. Flag outputs are checked when FLOAT_NORM_FLAGS_EN is defined.
module tb_float_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_sticky, in_inf, in_nan;
  logic [9:0]  in_exp;
  logic [26:0] in_man;
  logic        out_valid, out_ready;
  logic [31:0] dout;
`ifdef FLOAT_NORM_FLAGS_EN
  logic        out_ovf, out_unf, out_inexact;
`endif

  always #5 clk = ~clk;

  float_norm_round #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_man    (in_man),
    .in_sticky (in_sticky),
    .in_inf    (in_inf),
    .in_nan    (in_nan),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
`ifdef FLOAT_NORM_FLAGS_EN
    ,
    .out_ovf     (out_ovf),
    .out_unf     (out_unf),
    .out_inexact (out_inexact)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic [2:0]  f;    // {ovf, unf, inexact}
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Monitor: samples between edges, predicts the transfer at the next posedge.
  logic        held_v = 1'b0;
  logic [31:0] held_d;
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (held_v && out_valid) check("hold_stable", dout, held_d);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", out_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("dout", dout, e.d);
`ifdef FLOAT_NORM_FLAGS_EN
          check("flags", {out_ovf, out_unf, out_inexact}, e.f);
`endif
          if (e.chk_lat) check("latency", cyc - e.acc, 2);
        end
      end
      held_v = out_valid && !out_ready;
      held_d = dout;
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic send(input logic s, input logic [9:0] e, input logic [26:0] m,
                      input logic st, input logic inf, input logic nan,
                      input logic [31:0] d, input logic [2:0] f, input bit lat);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_man = m;
    in_sticky = st; in_inf = inf; in_nan = nan;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{d: d, f: f, acc: cyc, chk_lat: lat});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check(tag, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_man = '0;
    in_sticky = 1'b0; in_inf = 1'b0; in_nan = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_dout", dout, 0);
    check("reset_in_ready", in_ready, 1);

    // sign, exp, man, sticky, inf, nan, expected dout, {ovf,unf,inexact}
    send(0, 10'd127, 27'h1 << 26,                     0, 0, 0, 32'h3F80_0000, 3'b000, 1);
    send(0, 10'd127, 27'h1 << 24,                     0, 0, 0, 32'h3E80_0000, 3'b000, 1);
    send(1, 10'd127, 27'h0,                           0, 0, 0, 32'h8000_0000, 3'b000, 1);
    send(0, 10'd127, (27'h1 << 26) | 27'h4,           0, 0, 0, 32'h3F80_0000, 3'b001, 1);
    send(0, 10'd127, (27'h1 << 26) | 27'h8 | 27'h4,   0, 0, 0, 32'h3F80_0002, 3'b001, 1);
    send(0, 10'd127, (27'h1 << 26) | 27'h4,           1, 0, 0, 32'h3F80_0001, 3'b001, 1);
    send(0, 10'd127, 27'h7FF_FFFF,                    0, 0, 0, 32'h4000_0000, 3'b001, 1);
    send(0, 10'd254, 27'h7FF_FFFF,                    0, 0, 0, 32'h7F80_0000, 3'b101, 1);
    send(1, 10'd5,   27'h1 << 20,                     0, 0, 0, 32'h8000_0000, 3'b011, 1);
    send(1, 10'd1,   27'h1 << 26,                     0, 0, 0, 32'h8080_0000, 3'b000, 1);
    send(1, 10'd127, 27'h1 << 26,                     0, 1, 1, 32'h7FC0_0000, 3'b000, 1);
    send(1, 10'd127, 27'h1 << 26,                     0, 1, 0, 32'hFF80_0000, 3'b000, 1);
    drain("drain_directed");

    // Stall: five beats with the consumer blocked for six cycles.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(0, 10'(100 + i), 27'h1 << 26, 0, 0, 0, 32'(100 + i) << 23, 3'b000, 0);
      end
      begin
        repeat (4) @(negedge clk);
        #1;
        check("stall_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Reset while stalled with two beats in flight.
    out_ready = 1'b0;
    send(0, 10'd127, 27'h1 << 26, 0, 0, 0, 32'h3F80_0000, 3'b000, 0);
    send(0, 10'd128, 27'h1 << 26, 0, 0, 0, 32'h4000_0000, 3'b000, 0);
    repeat (2) @(negedge clk);
    #1;
    check("stall_out_valid", out_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("no_stale_beat", out_valid, 0);
    send(0, 10'd126, 27'h1 << 26, 0, 0, 0, 32'h3F00_0000, 3'b000, 1);
    drain("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
